// File: rtl/instr_mem_dp_pkg.sv
// Shared definitions for the fetch-stage instruction memory: the
// instruction word layout, its reset value and the stage-1 data source select.
package instr_mem_dp_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] operand;
    } instruction_s;

    // Value presented on instruction_o out of reset, before any read completes.
    localparam instruction_s instr_zero_c = '0;

    // Where the stage-1 word comes from. zero: nothing read since reset.
    // ram: the registered array read. byp: the write data captured on a collision.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_BYP  = 2'd2
    } s1_src_e;

endpackage

// File: rtl/instr_ram_1w1r.sv
// Bare 1-write/1-read instruction array with a registered read port.
// On a same-edge read/write to one address the read returns the old contents.
// The array and the read register have no reset.
module instr_ram_1w1r
    import instr_mem_dp_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [addr_width_p-1:0] waddr,
    input  instruction_s            wdata,
    input  logic                    re,
    input  logic [addr_width_p-1:0] raddr,
    output instruction_s            rdata
);

    localparam int depth_lp = 1 << addr_width_p;

    instruction_s mem [depth_lp];

    // Write and registered read; the read samples the array before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_dp.sv
// Fetch-stage instruction memory. A loader writes through a dedicated port,
// either at an explicit address or at an auto-incrementing load pointer.
// The fetch unit reads through a valid/stall port with latency 1 or 2.
//
// Read handshake: a request is accepted on an edge where rd_v_i=1 and
// stall_i=0. While stall_i=1 nothing is accepted and every pipeline register
// and valid holds, so rd_v_o and instruction_o stay constant. The requester
// keeps rd_v_i/raddr_i steady until the request is accepted. rd_v_o marks
// instruction_o as valid. When rd_v_o=0, instruction_o keeps its last value.
module instr_mem_dp
    import instr_mem_dp_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int out_reg_p    = 0,
    parameter int bypass_p     = 1
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    wen_i,
    input  logic                    wauto_i,
    input  logic [addr_width_p-1:0] waddr_i,
    input  instruction_s            wdata_i,
    input  logic                    load_clr_i,
    output logic [addr_width_p-1:0] load_ptr_o,
    input  logic                    rd_v_i,
    input  logic [addr_width_p-1:0] raddr_i,
    input  logic                    stall_i,
    output logic                    rd_v_o,
    output instruction_s            instruction_o
);

    localparam logic [addr_width_p-1:0] one_lp = 1;

    logic [addr_width_p-1:0] load_ptr_q;
    logic [addr_width_p-1:0] waddr_eff;
    logic                    wr_en;
    logic                    rd_acc;
    logic                    collide;
    instruction_s            ram_rdata;

    logic                    s1_v;
    s1_src_e                 s1_src;
    instruction_s            s1_wdata;
    instruction_s            s1_data;

    // Resolve the write address. Writes and reads are suppressed while reset is asserted.
    assign waddr_eff = wauto_i ? load_ptr_q : waddr_i;
    assign wr_en     = wen_i & n_reset;
    assign rd_acc    = rd_v_i & ~stall_i & n_reset;
    assign collide   = wen_i && (waddr_eff == raddr_i);

    instr_ram_1w1r #(
        .addr_width_p(addr_width_p)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(waddr_eff),
        .wdata(wdata_i),
        .re   (rd_acc),
        .raddr(raddr_i),
        .rdata(ram_rdata)
    );

    // Load pointer: a clear wins over the post-write increment; the increment wraps.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            load_ptr_q <= '0;
        end else if (load_clr_i) begin
            load_ptr_q <= '0;
        end else if (wen_i && wauto_i) begin
            load_ptr_q <= load_ptr_q + one_lp;
        end
    end

    assign load_ptr_o = load_ptr_q;

    // Stage 1 valid and data-source select. A bubble clears only the valid.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_v     <= 1'b0;
            s1_src   <= SRC_ZERO;
            s1_wdata <= instr_zero_c;
        end else if (!stall_i) begin
            s1_v <= rd_v_i;
            if (rd_v_i) begin
                s1_src   <= ((bypass_p != 0) && collide) ? SRC_BYP : SRC_RAM;
                s1_wdata <= wdata_i;
            end
        end
    end

    // Stage 1 data. The array read register or the captured write data, frozen between accepts.
    always_comb begin
        s1_data = instr_zero_c;
        unique case (s1_src)
            SRC_RAM:  s1_data = ram_rdata;
            SRC_BYP:  s1_data = s1_wdata;
            default:  s1_data = instr_zero_c;
        endcase
    end

    generate
        if (out_reg_p != 0) begin : g_stage2
            logic         s2_v;
            instruction_s s2_data;

            // Stage 2 advances only on unstalled edges and keeps its data across bubbles.
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    s2_v    <= 1'b0;
                    s2_data <= instr_zero_c;
                end else if (!stall_i) begin
                    s2_v <= s1_v;
                    if (s1_v) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_v_o        = s2_v;
            assign instruction_o = s2_data;
        end else begin : g_stage1_out
            assign rd_v_o        = s1_v;
            assign instruction_o = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_dp.sv
// Bench for instr_mem_dp. Four instances share one stimulus stream and cover
// every combination of out_reg_p and bypass_p, with an 8-word memory.
// Index g: out_reg_p = g%2, bypass_p = g/2.
module tb_instr_mem_dp;
    import instr_mem_dp_pkg::*;

    localparam int aw    = 3;
    localparam int depth = 1 << aw;
    localparam int ni    = 4;
    localparam int iw    = $bits(instruction_s);

    logic            clk;
    logic            n_reset;
    logic            wen_i;
    logic            wauto_i;
    logic [aw-1:0]   waddr_i;
    instruction_s    wdata_i;
    logic            load_clr_i;
    logic            rd_v_i;
    logic [aw-1:0]   raddr_i;
    logic            stall_i;

    logic [ni-1:0]   rd_v_o_a;
    instruction_s    instr_a [ni];
    logic [aw-1:0]   lp_a [ni];

    for (genvar g = 0; g < ni; g++) begin : g_dut
        instr_mem_dp #(
            .addr_width_p(aw),
            .out_reg_p   (g % 2),
            .bypass_p    (g / 2)
        ) u_dut (
            .clk          (clk),
            .n_reset      (n_reset),
            .wen_i        (wen_i),
            .wauto_i      (wauto_i),
            .waddr_i      (waddr_i),
            .wdata_i      (wdata_i),
            .load_clr_i   (load_clr_i),
            .load_ptr_o   (lp_a[g]),
            .rd_v_i       (rd_v_i),
            .raddr_i      (raddr_i),
            .stall_i      (stall_i),
            .rd_v_o       (rd_v_o_a[g]),
            .instruction_o(instr_a[g])
        );
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model and scoreboard ----------------
    logic [iw-1:0] mem_m [depth];
    logic [aw-1:0] ptr_m;
    logic [iw-1:0] exp_q [ni][$];
    logic          exp_v [ni];
    logic          pend_v [ni];
    logic          new_out [ni];
    logic [iw-1:0] hold_m [ni];
    int            checks;
    int            errors;

    function automatic int lat_of(input int g);
        return 1 + (g % 2);
    endfunction

    function automatic bit write_first(input int g);
        return (g / 2) != 0;
    endfunction

    task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        ptr_m = '0;
        for (int g = 0; g < ni; g++) begin
            exp_q[g].delete();
            exp_v[g]   = 1'b0;
            pend_v[g]  = 1'b0;
            new_out[g] = 1'b0;
            hold_m[g]  = '0;
        end
    endtask

    // Applies the memory rules for one rising edge, using the inputs as they stand at that edge.
    task automatic model_edge();
        logic [aw-1:0] wa;
        if (!n_reset) begin
            model_clear();
            return;
        end
        wa = wauto_i ? ptr_m : waddr_i;
        for (int g = 0; g < ni; g++) begin
            new_out[g] = 1'b0;
            if (!stall_i) begin
                if (rd_v_i) begin
                    if (wen_i && wa == raddr_i && write_first(g))
                        exp_q[g].push_back(wdata_i);
                    else
                        exp_q[g].push_back(mem_m[raddr_i]);
                end
                // The response appears lat_of(g) unstalled edges after its request.
                if (lat_of(g) == 1) begin
                    exp_v[g] = rd_v_i;
                end else begin
                    exp_v[g]  = pend_v[g];
                    pend_v[g] = rd_v_i;
                end
                new_out[g] = exp_v[g];
            end
        end
        if (wen_i) mem_m[wa] = wdata_i;
        if (load_clr_i) ptr_m = '0;
        else if (wen_i && wauto_i) ptr_m = ptr_m + 3'd1;
    endtask

    // Monitor: pops one expected word per newly presented output and checks all outputs.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < ni; g++) begin
            if (new_out[g]) begin
                new_out[g] = 1'b0;
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL underflow dut%0d: output with no expected entry at %0t", g, $time);
                end else begin
                    hold_m[g] = exp_q[g].pop_front();
                end
            end
            check("rd_v_o", g, 64'(rd_v_o_a[g]), 64'(exp_v[g]));
            check("instruction_o", g, 64'(instr_a[g]), 64'(hold_m[g]));
            check("load_ptr_o", g, 64'(lp_a[g]), 64'(ptr_m));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        wen_i      = 1'b0;
        wauto_i    = 1'b0;
        waddr_i    = '0;
        load_clr_i = 1'b0;
        rd_v_i     = 1'b0;
        raddr_i    = '0;
        stall_i    = 1'b0;
    endtask

    task automatic auto_write(input logic [iw-1:0] d);
        wen_i   = 1'b1;
        wauto_i = 1'b1;
        wdata_i = d;
        tick();
        wen_i   = 1'b0;
        wauto_i = 1'b0;
    endtask

    task automatic addr_write(input logic [aw-1:0] a, input logic [iw-1:0] d);
        wen_i   = 1'b1;
        wauto_i = 1'b0;
        waddr_i = a;
        wdata_i = d;
        tick();
        wen_i   = 1'b0;
    endtask

    task automatic assert_reset_now();
        n_reset = 1'b0;
        model_clear();
        #1;
        for (int g = 0; g < ni; g++) begin
            check("reset_rd_v_o", g, 64'(rd_v_o_a[g]), 64'(0));
            check("reset_instruction_o", g, 64'(instr_a[g]), 64'(0));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < depth; i++) mem_m[i] = '0;
        set_idle();
        wdata_i = '0;
        model_clear();

        // Reset held with a read request pending.
        n_reset = 1'b0;
        rd_v_i  = 1'b1;
        repeat (3) tick();
        n_reset = 1'b1;
        rd_v_i  = 1'b0;
        tick();

        // Auto load of four words, then back-to-back reads of 0..3.
        load_clr_i = 1'b1;
        tick();
        load_clr_i = 1'b0;
        for (int i = 1; i <= 4; i++) auto_write(32'h11 * i);
        for (int i = 0; i < 4; i++) begin
            rd_v_i  = 1'b1;
            raddr_i = 3'(i);
            tick();
        end
        rd_v_i = 1'b0;

        // Fill 4..7 so the pointer wraps to 0, then one more write lands at 0.
        for (int i = 5; i <= 8; i++) auto_write(32'h11 * i);
        auto_write(32'hA0);
        rd_v_i  = 1'b1;
        raddr_i = 3'd0;
        tick();
        rd_v_i = 1'b0;
        repeat (2) tick();

        // Same-edge collision on address 5, then a plain read of 5.
        addr_write(3'd5, 32'hAA);
        wen_i = 1'b1; waddr_i = 3'd5; wdata_i = 32'hBB;
        rd_v_i = 1'b1; raddr_i = 3'd5;
        tick();
        wen_i = 1'b0;
        tick();
        rd_v_i = 1'b0;
        repeat (2) tick();

        // Collision through the load pointer (pointer currently 1).
        wen_i = 1'b1; wauto_i = 1'b1; wdata_i = 32'hC1;
        rd_v_i = 1'b1; raddr_i = 3'd1;
        tick();
        set_idle();
        repeat (2) tick();

        // Stall: read 3, then hold a new request while writing 3 under stall.
        addr_write(3'd3, 32'h33);
        rd_v_i = 1'b1; raddr_i = 3'd3;
        tick();
        stall_i = 1'b1; raddr_i = 3'd2;
        wen_i = 1'b1; waddr_i = 3'd3; wdata_i = 32'h99;
        repeat (3) tick();
        stall_i = 1'b0; wen_i = 1'b0;
        tick();
        rd_v_i = 1'b0;
        repeat (3) tick();

        // Reset while a read is in flight.
        rd_v_i = 1'b1; raddr_i = 3'd1;
        tick();
        rd_v_i = 1'b0;
        tick();
        assert_reset_now();
        @(negedge clk);
        repeat (2) tick();
        n_reset = 1'b1;
        repeat (3) tick();

        // Randomized traffic; a stalled request is held until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!(stall_i && rd_v_i)) begin
                rd_v_i  = ($urandom_range(0, 3) != 0);
                raddr_i = 3'($urandom_range(0, depth - 1));
            end
            stall_i    = ($urandom_range(0, 3) == 0);
            wen_i      = 1'($urandom_range(0, 1));
            wauto_i    = 1'($urandom_range(0, 1));
            waddr_i    = 3'($urandom_range(0, depth - 1));
            wdata_i    = $urandom;
            load_clr_i = ($urandom_range(0, 15) == 0);
            tick();
        end

        set_idle();
        repeat (4) tick();
        for (int g = 0; g < ni; g++) check("drained", g, 64'(exp_q[g].size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_dp.md
# instr_mem_dp

Parametrised 1-write/1-read synchronous instruction memory for the fetch stage. A loader writes programs through a dedicated write port, with optional auto-incrementing write address. The fetch unit reads concurrently through a valid/stall read port with 1 or 2 cycles of latency, configurable read-during-write behaviour, and hold-on-stall output registers.

## Interface
- addr_width_p, 10, word-address width; depth = 2**addr_width_p instruction_s words
- out_reg_p, 0, 0 gives read latency 1; 1 adds an output register stage for latency 2
- bypass_p, 1, 1 = write-first on same-address read/write collision; 0 = read-first (old data)

- clk  in  1  clock, all state updates on posedge
- n_reset  in  1  asynchronous, active-low reset
- wen_i  in  1  write enable
- wauto_i  in  1  1 = write to internal load pointer; 0 = write to waddr_i
- waddr_i  in  addr_width_p  explicit write address
- wdata_i  in  instruction_s  write data
- load_clr_i  in  1  synchronously clears load pointer to 0
- load_ptr_o  out  addr_width_p  current load pointer
- rd_v_i  in  1  read request valid
- raddr_i  in  addr_width_p  read address
- stall_i  in  1  downstream stall; freezes the read pipeline
- rd_v_o  out  1  instruction_o valid
- instruction_o  out  instruction_s  read data

## Operation
- Reset (n_reset low, async): rd_v_o=0, instruction_o=0, load_ptr_o=0, all pipeline valids=0. Memory contents are not reset and are undefined after power-up. Writes and reads while in reset are ignored.
- Write: wen_i=1 writes wdata_i to (wauto_i ? load_ptr : waddr_i) at posedge. The write is independent of stall_i.
- Load pointer: increments by 1 after each wen_i&wauto_i write and wraps from 2**addr_width_p-1 to 0. load_clr_i has priority over increment. If load_clr_i and an auto write occur together, the write goes to the old pointer and the pointer becomes 0.
- Read accepted when rd_v_i=1 and stall_i=0. When stall_i=1 the request is not accepted, and the requester must hold it.
- Data capture: stage-1 register captures mem[raddr_i] at the accept edge. On a collision (wen_i, resolved write address == raddr_i, same edge):
  - bypass_p=1: captures wdata_i.
  - bypass_p=0: captures old contents.
- Captured data is a snapshot. Later writes to that address do not alter in-flight data.
- Stall: while stall_i=1 all stage registers and valids hold their values. rd_v_o/instruction_o stay constant.
- A cycle with stall_i=0 and rd_v_i=0 inserts a bubble (stage valid 0). instruction_o holds its last value when rd_v_o=0.
- Reset mid-operation: in-flight reads are dropped, with no valid output after reset release until a new accept.

## Timing
- out_reg_p=0: accept at edge N gives rd_v_o=1 and data after edge N (usable cycle N+1).
- out_reg_p=1: data after edge N+1. Stage 2 advances only when stall_i=0.
- Throughput: one read per unstalled cycle, back-to-back, no bubbles.
- Write-to-read: with bypass_p=0, a read at the edge after the write sees the new data (latency 1 write visibility).
- load_ptr_o is registered and updates at the write edge.

## Structure
- instruction_s stays in the shared definitions package. Add a package localparam for the instruction_s zero/reset value used by instruction_o.
- Sub-module instr_ram_1w1r (addr_width_p): the bare array with a registered read port and a read-first collision rule. The top adds the bypass mux, load pointer, valid/stall pipeline and optional stage 2.

## Test plan
- Reset: hold n_reset=0 with rd_v_i=1 → rd_v_o=0, instruction_o=0, load_ptr_o=0. Release, accept a read → rd_v_o=1 after 1 (out_reg_p=0) or 2 (out_reg_p=1) edges.
- Auto load: load_clr_i, then 4 writes with wauto_i=1 and data 0x11,0x22,0x33,0x44 → load_ptr_o=4. Reads of addresses 0..3 back-to-back return the same sequence on consecutive cycles.
- Wrap (addr_width_p=2): 5 auto writes of 0xA0..0xA4 → load_ptr_o=1, and address 0 reads 0xA4.
- Collision: mem[5]=0xAA, write 0xBB to 5 with a same-edge read of 5 → 0xBB when bypass_p=1, 0xAA when bypass_p=0. A following read returns 0xBB in both cases.
- Stall: accept a read of address 3 (0x33), raise stall_i for 3 cycles while writing 0x99 to 3 → instruction_o holds 0x33 and rd_v_o holds 1. A read request presented during the stall is accepted only after stall_i falls.
- Mid-flight reset (out_reg_p=1): accept a read, assert n_reset one edge later → rd_v_o=0 immediately and stays 0 after release until a new accept.
